// File: rtl/rs_syndrome_calc_if.sv
// Handshake bundle between the register-write front end, the syndrome
// calculator and the downstream error-locator stage.
interface rs_syndrome_calc_if #(
   parameter int NSYM = 4
);
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_last;
   logic              in_ready;
   logic              synd_valid;
   logic              synd_ack;
   logic [8*NSYM-1:0] synd_out;
   logic              synd_nonzero;
   logic              len_err;
   logic              busy;

   modport master (
      output start, in_valid, in_data, in_last, synd_ack,
      input  in_ready, synd_valid, synd_out, synd_nonzero, len_err, busy
   );

   modport slave (
      input  start, in_valid, in_data, in_last, synd_ack,
      output in_ready, synd_valid, synd_out, synd_nonzero, len_err, busy
   );
endinterface

// File: rtl/rs_syndrome_calc.sv
// Streaming Reed-Solomon syndrome calculator over GF(2^8), poly 0x11D.
// Horner update S_j <= S_j*alpha^j ^ r for all j in parallel, one symbol per cycle.
module rs_syndrome_calc #(
   parameter int NSYM    = 4,
   parameter int MAX_LEN = 255
) (
   input  logic               clk,
   input  logic               rst,
   rs_syndrome_calc_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);
   localparam logic [7:0] MIN_LEN_C = 8'(NSYM + 1);

   // Multiply by x modulo x^8+x^4+x^3+x^2+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
   endfunction

   function automatic logic [7:0] alpha_pow(input int e);
      logic [7:0] p;
      p = 8'h01;
      for (int i = 0; i < e; i++) p = xtime(p);
      return p;
   endfunction

   // With a constant b this folds to a fixed XOR network per output bit.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   logic [1:0]        state;
   logic [7:0]        cnt;
   logic [7:0]        cnt_next;
   logic [8*NSYM-1:0] synd;
   logic [8*NSYM-1:0] synd_next;
   logic              len_err_q;
   logic              end_of_word;

   genvar j;
   generate
      for (j = 0; j < NSYM; j++) begin : g_horner
         localparam logic [7:0] ALPHA_J = alpha_pow(j);
         assign synd_next[8*j +: 8] = gf_mul(synd[8*j +: 8], ALPHA_J) ^ bus.in_data;
      end
   endgenerate

   assign cnt_next    = cnt + 8'd1;
   assign end_of_word = bus.in_last || (cnt_next == MAX_LEN_C);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         synd      <= '0;
         cnt       <= 8'd0;
         len_err_q <= 1'b0;
      end else if (bus.start) begin
         // start outranks ack and any symbol offered in the same cycle
         state     <= ST_ACCUM;
         synd      <= '0;
         cnt       <= 8'd0;
         len_err_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: ;
            ST_ACCUM: begin
               if (bus.in_valid) begin
                  synd <= synd_next;
                  cnt  <= cnt_next;
                  if (end_of_word) begin
                     state     <= ST_DONE;
                     len_err_q <= (cnt_next < MIN_LEN_C) || !bus.in_last;
                  end
               end
            end
            ST_DONE: begin
               if (bus.synd_ack) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready     = (state == ST_ACCUM);
   assign bus.busy         = (state == ST_ACCUM);
   assign bus.synd_valid   = (state == ST_DONE);
   assign bus.synd_out     = synd;
   assign bus.synd_nonzero = |synd;
   assign bus.len_err      = len_err_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc (NSYM=4, MAX_LEN=255) with
// hand-computed GF(2^8) syndromes.
module tb_rs_syndrome_calc;

   localparam int NSYM = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   rs_syndrome_calc_if #(.NSYM(NSYM)) bus ();

   rs_syndrome_calc #(.NSYM(NSYM), .MAX_LEN(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      bus.synd_ack = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
   endtask

   task automatic send_sym(input logic [7:0] d, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      cycle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic ack_result();
      bus.synd_ack = 1'b1;
      cycle();
      bus.synd_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      cycle();
      cycle();
      rst = 1'b0;
      n_checks++;
      if ({bus.in_ready, bus.synd_valid, bus.synd_nonzero, bus.len_err, bus.busy} !== 5'b0
          || bus.synd_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b nz=%b le=%b busy=%b synd=%h, want all 0",
                  bus.in_ready, bus.synd_valid, bus.synd_nonzero, bus.len_err, bus.busy, bus.synd_out);
      end
      do_start();
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_start: got rdy=%b busy=%b, want 1 1", bus.in_ready, bus.busy);
      end
      send_sym(8'h11, 1'b0);
      send_sym(8'h22, 1'b0);
      send_sym(8'h33, 1'b0);
      n_checks++;
      if (bus.synd_out === 32'h0) begin
         n_fail++;
         $display("FAIL accum_nonzero: got synd=%h, want nonzero before reset", bus.synd_out);
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      n_checks++;
      if ({bus.in_ready, bus.synd_valid, bus.synd_nonzero, bus.len_err, bus.busy} !== 5'b0
          || bus.synd_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_accum: got rdy=%b vld=%b nz=%b le=%b busy=%b synd=%h, want all 0",
                  bus.in_ready, bus.synd_valid, bus.synd_nonzero, bus.len_err, bus.busy, bus.synd_out);
      end
      do_start();
      for (int i = 0; i < 4; i++) send_sym(8'h00, 1'b0);
      send_sym(8'h01, 1'b1);
      n_checks++;
      if (bus.synd_valid !== 1'b1 || bus.synd_out !== 32'h01010101
          || bus.synd_nonzero !== 1'b1 || bus.len_err !== 1'b0) begin
         n_fail++;
         $display("FAIL unit_word: got vld=%b synd=%h nz=%b le=%b, want 1 01010101 1 0",
                  bus.synd_valid, bus.synd_out, bus.synd_nonzero, bus.len_err);
      end
      ack_result();
   endtask

   task automatic test_zero_codeword();
      do_start();
      for (int i = 0; i < 254; i++) send_sym(8'h00, 1'b0);
      n_checks++;
      if (bus.synd_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_before_last: got vld=%b rdy=%b, want 0 1", bus.synd_valid, bus.in_ready);
      end
      send_sym(8'h00, 1'b1);
      n_checks++;
      if (bus.synd_valid !== 1'b1 || bus.synd_out !== 32'h0
          || bus.synd_nonzero !== 1'b0 || bus.len_err !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_word: got vld=%b synd=%h nz=%b le=%b, want 1 00000000 0 0",
                  bus.synd_valid, bus.synd_out, bus.synd_nonzero, bus.len_err);
      end
      ack_result();
   endtask

   // Leaves the block in DONE for the back-pressure test.
   task automatic test_impulse();
      do_start();
      send_sym(8'h01, 1'b0);
      for (int i = 0; i < 3; i++) send_sym(8'h00, 1'b0);
      send_sym(8'h00, 1'b1);
      n_checks++;
      if (bus.synd_valid !== 1'b1 || bus.synd_out !== 32'hCD1D1001
          || bus.synd_nonzero !== 1'b1 || bus.len_err !== 1'b0) begin
         n_fail++;
         $display("FAIL impulse: got vld=%b synd=%h nz=%b le=%b, want 1 cd1d1001 1 0",
                  bus.synd_valid, bus.synd_out, bus.synd_nonzero, bus.len_err);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.in_data  = 8'hFF;
         bus.in_last  = 1'b1;
         cycle();
         n_checks++;
         if (bus.synd_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.synd_out !== 32'hCD1D1001) begin
            n_fail++;
            $display("FAIL hold_done[%0d]: got vld=%b rdy=%b synd=%h, want 1 0 cd1d1001",
                     i, bus.synd_valid, bus.in_ready, bus.synd_out);
         end
      end
      idle_inputs();
      ack_result();
      n_checks++;
      if (bus.synd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_to_idle: got vld=%b busy=%b rdy=%b, want 0 0 0",
                  bus.synd_valid, bus.busy, bus.in_ready);
      end
      bus.synd_ack = 1'b1;
      cycle();
      bus.synd_ack = 1'b0;
      n_checks++;
      if (bus.synd_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_in_idle: got vld=%b busy=%b, want 0 0", bus.synd_valid, bus.busy);
      end
   endtask

   task automatic test_len_err();
      do_start();
      send_sym(8'h01, 1'b0);
      send_sym(8'h02, 1'b0);
      send_sym(8'h03, 1'b1);
      n_checks++;
      if (bus.synd_valid !== 1'b1 || bus.len_err !== 1'b1) begin
         n_fail++;
         $display("FAIL short_word: got vld=%b le=%b, want 1 1", bus.synd_valid, bus.len_err);
      end
      ack_result();
      do_start();
      n_checks++;
      if (bus.len_err !== 1'b0) begin
         n_fail++;
         $display("FAIL len_err_clear: got le=%b, want 0", bus.len_err);
      end
      for (int i = 0; i < 254; i++) send_sym(8'h00, 1'b0);
      n_checks++;
      if (bus.synd_valid !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL max_before_255: got vld=%b busy=%b, want 0 1", bus.synd_valid, bus.busy);
      end
      send_sym(8'h00, 1'b0);
      n_checks++;
      if (bus.synd_valid !== 1'b1 || bus.len_err !== 1'b1 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL max_no_last: got vld=%b le=%b rdy=%b, want 1 1 0",
                  bus.synd_valid, bus.len_err, bus.in_ready);
      end
   endtask

   // Entered with the block in DONE and len_err set.
   task automatic test_start_over_ack();
      bus.start    = 1'b1;
      bus.synd_ack = 1'b1;
      cycle();
      idle_inputs();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.synd_valid !== 1'b0 || bus.len_err !== 1'b0 || bus.synd_out !== 32'h0) begin
         n_fail++;
         $display("FAIL start_beats_ack: got busy=%b vld=%b le=%b synd=%h, want 1 0 0 00000000",
                  bus.busy, bus.synd_valid, bus.len_err, bus.synd_out);
      end
   endtask

   task automatic test_restart();
      send_sym(8'h37, 1'b0);
      send_sym(8'hA5, 1'b0);
      bus.start    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      cycle();
      idle_inputs();
      n_checks++;
      if (bus.synd_out !== 32'h0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_drop: got synd=%h busy=%b, want 00000000 1", bus.synd_out, bus.busy);
      end
      for (int i = 0; i < 4; i++) send_sym(8'h00, 1'b0);
      send_sym(8'h02, 1'b1);
      n_checks++;
      if (bus.synd_valid !== 1'b1 || bus.synd_out !== 32'h02020202 || bus.len_err !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_word: got vld=%b synd=%h le=%b, want 1 02020202 0",
                  bus.synd_valid, bus.synd_out, bus.len_err);
      end
      ack_result();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_zero_codeword();
      test_impulse();
      test_backpressure();
      test_len_err();
      test_start_over_ack();
      test_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Streaming syndrome calculator for the Reed-Solomon decoder peripheral. Accepts a received codeword one GF(2^8) symbol per cycle from the peripheral's register-write front end and computes the NSYM syndromes S_j = r(α^j), j = 0..NSYM-1, using Horner evaluation. The syndrome vector, plus a nonzero flag and a length-error flag, is handed downstream to the error-locator stage.

## Interface

Parameters:
- NSYM, 4: number of parity symbols and syndromes (2..16).
- MAX_LEN, 255: maximum codeword length in symbols (NSYM+1..255).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse; clears syndromes and count, enters ACCUM.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  8  received symbol, highest-degree coefficient first.
- in_last  input  1  qualifies the final symbol of the codeword.
- in_ready  output  1  block accepts a symbol this cycle.
- synd_valid  output  1  synd_out, synd_nonzero and len_err are valid.
- synd_ack  input  1  downstream consumed the result.
- synd_out  output  8*NSYM  S_j in bits [8j+7:8j].
- synd_nonzero  output  1  OR-reduction of all syndromes.
- len_err  output  1  codeword length out of range.
- busy  output  1  state is ACCUM.

## Operation

- Field: GF(2^8), primitive polynomial 0x11D, α = 0x02, first consecutive root α^0.
- Per accepted symbol: S_j <= (S_j ⊗ α^j) ⊕ in_data, for all j in parallel. Each ⊗α^j is a constant multiplier (XOR network); no table lookups.
- Symbol counter cnt, 8 bits, cleared on start, incremented per accepted symbol.
- States: IDLE, ACCUM, DONE.
  - IDLE: in_ready=0, synd_valid=0. start -> ACCUM.
  - ACCUM: in_ready=1. Accept when in_valid. If the accepted symbol has in_last=1, or cnt reaches MAX_LEN with it, -> DONE.
  - DONE: synd_valid=1, syndromes frozen, in_ready=0. synd_ack -> IDLE.
- len_err is set on entering DONE if the final count is < NSYM+1, or if MAX_LEN was reached without in_last. It is cleared on start.
- start has priority over everything in every state: it clears S_j, cnt and len_err and enters ACCUM. A symbol presented in the same cycle is dropped.
- in_valid outside ACCUM is ignored. synd_ack outside DONE is ignored.
- rst: state IDLE; all S_j=0, cnt=0, len_err=0. All outputs 0: in_ready, synd_valid, synd_out, synd_nonzero, len_err, busy.

## Timing

- Throughput: one symbol per cycle in ACCUM, with no bubbles.
- in_ready and busy are decoded directly from state. in_ready rises the cycle after start.
- S_j reflects an accepted symbol from the next edge.
- synd_valid rises the cycle after the last symbol is accepted (latency 1). It holds until the edge on which synd_ack is sampled high, then falls.
- synd_nonzero is combinational from the S_j registers.
- start and synd_ack in the same DONE cycle: start wins, giving ACCUM with cleared state.
- Worst-case combinational path: one constant α^(NSYM-1) multiply plus one XOR per bit.

## Test plan

- Reset mid-ACCUM after 3 symbols -> next cycle all outputs 0 and state IDLE. A subsequent start plus 5 symbols 00 00 00 00 01 with last -> synd_out={01,01,01,01}, synd_nonzero=1, len_err=0.
- Zero codeword: start, 255 symbols of 00, last on the 255th -> synd_out=0, synd_nonzero=0, len_err=0, synd_valid one cycle after the last accept.
- Impulse at top degree, NSYM=4: 01 00 00 00 00 (last) -> S0=01, S1=10, S2=1D, S3=CD, i.e. synd_out=0xCD1D1001.
- Back-pressure and ack: hold synd_ack=0 for 10 cycles -> synd_valid stays 1 and in_ready stays 0, and in_valid pulses do not alter synd_out. Assert synd_ack -> synd_valid=0 and IDLE next cycle.
- Length errors: last on the 3rd symbol -> len_err=1, synd_valid=1. Separately, 255 symbols with no last -> DONE after the 255th, len_err=1.
- Restart: start issued after 2 symbols with in_valid=1 in the same cycle -> that symbol dropped and cnt=0. Then 02 preceded by four 00, with last -> synd_out={02,02,02,02}.
